// File: rtl/fp_div_pkg.sv
// Shared types and constants for the sequential floating-point divider.
//   state_e      : control FSM states
//   RM_*         : rounding-mode encodings of rm_i
//   FLAG_*       : bit positions inside the 5-bit flags vector
//   fp_bias/fp_qnan/fp_inf/fp_max_finite : format constants derived from EXP_W, MAN_W
package fp_div_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    ITER  = 3'd2,
    ROUND = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RTZ = 2'b01;
  localparam logic [1:0] RM_RUP = 2'b10;
  localparam logic [1:0] RM_RDN = 2'b11;

  localparam int unsigned FLAG_W  = 5;
  localparam int unsigned FLAG_NX = 0;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_DZ = 3;
  localparam int unsigned FLAG_NV = 4;

  // Wide scratch width for building format constants; callers truncate.
  localparam int unsigned CONST_W = 128;

  function automatic int unsigned fp_bias(input int unsigned exp_w);
    return (32'd1 << (exp_w - 1)) - 32'd1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  function automatic logic [CONST_W-1:0] fp_qnan(input int unsigned exp_w,
                                                 input int unsigned man_w);
    logic [CONST_W-1:0] v;
    v = ((CONST_W'(1) << exp_w) - CONST_W'(1)) << man_w;
    v = v | (CONST_W'(1) << (man_w - 1));
    return v;
  endfunction

  // Unsigned infinity magnitude.
  function automatic logic [CONST_W-1:0] fp_inf(input int unsigned exp_w,
                                                input int unsigned man_w);
    return ((CONST_W'(1) << exp_w) - CONST_W'(1)) << man_w;
  endfunction

  // Largest finite magnitude.
  function automatic logic [CONST_W-1:0] fp_max_finite(input int unsigned exp_w,
                                                       input int unsigned man_w);
    logic [CONST_W-1:0] v;
    v = ((CONST_W'(1) << exp_w) - CONST_W'(2)) << man_w;
    v = v | ((CONST_W'(1) << man_w) - CONST_W'(1));
    return v;
  endfunction

endpackage

// File: rtl/fp_div_iter.sv
// Radix-2 restoring mantissa divider, one quotient bit per clock.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   start_i          : load operands and begin (ignored fields reset each start)
//   dividend_i       : MAN_W+1-bit normalised dividend mantissa (hidden bit set)
//   divisor_i        : MAN_W+1-bit normalised divisor mantissa (hidden bit set)
//   busy_o           : iterations in progress
//   final_o          : high during the cycle that produces the last quotient bit
//   done_o           : quotient/remainder complete, held until next start
//   quo_o            : ITERS quotient bits, MSB is the integer bit
//   rem_o            : partial remainder after the last step (nonzero => inexact)
module fp_div_iter
  import fp_div_pkg::*;
#(
  parameter int unsigned MAN_W = 23,
  parameter int unsigned ITERS = MAN_W + 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [MAN_W:0]     dividend_i,
  input  logic [MAN_W:0]     divisor_i,
  output logic               busy_o,
  output logic               final_o,
  output logic               done_o,
  output logic [ITERS-1:0]   quo_o,
  output logic [MAN_W+1:0]   rem_o
);

  localparam int unsigned OP_W  = MAN_W + 1;
  localparam int unsigned REM_W = MAN_W + 2;
  localparam int unsigned CNT_W = $clog2(ITERS + 1);

  logic [REM_W-1:0] rem_q;
  logic [OP_W-1:0]  div_q;
  logic [ITERS-1:0] quo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             final_q;
  logic             done_q;

  logic [REM_W:0]   trial_c;
  logic             ge_c;
  logic [REM_W-1:0] rem_sel_c;

  // Trial subtract; remainder stays below the divisor after each step,
  // so doubling it always fits in REM_W bits.
  always_comb begin
    trial_c   = {1'b0, rem_q} - {2'b00, div_q};
    ge_c      = ~trial_c[REM_W];
    rem_sel_c = ge_c ? trial_c[REM_W-1:0] : rem_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rem_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      final_q <= 1'b0;
      done_q  <= 1'b0;
    end else if (start_i) begin
      rem_q   <= {1'b0, dividend_i};
      div_q   <= divisor_i;
      quo_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
      final_q <= (ITERS == 1);
      done_q  <= 1'b0;
    end else if (busy_q) begin
      quo_q <= {quo_q[ITERS-2:0], ge_c};
      rem_q <= rem_sel_c << 1;
      cnt_q <= cnt_q + CNT_W'(1);
      if (final_q) begin
        busy_q  <= 1'b0;
        final_q <= 1'b0;
        done_q  <= 1'b1;
      end else begin
        final_q <= (cnt_q == CNT_W'(ITERS - 2));
      end
    end
  end

  assign busy_o  = busy_q;
  assign final_o = final_q;
  assign done_o  = done_q;
  assign quo_o   = quo_q;
  assign rem_o   = rem_q;

endmodule

// File: rtl/fp_div_seq.sv
// Multi-cycle floating-point divider (result = a / b) with valid/ready on both
// sides and one operation in flight.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   in_valid_i/in_ready_o : operand handshake; in_ready_o high only in IDLE
//   a_i, b_i, rm_i        : dividend, divisor, rounding mode (sampled on accept)
//   out_valid_o/out_ready_i : result handshake; result held until accepted
//   result_o              : quotient
//   flags_o               : {invalid, div_by_zero, overflow, underflow, inexact}
module fp_div_seq
  import fp_div_pkg::*;
#(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned ITERS = MAN_W + 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [EXP_W+MAN_W:0]     a_i,
  input  logic [EXP_W+MAN_W:0]     b_i,
  input  logic [1:0]               rm_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [EXP_W+MAN_W:0]     result_o,
  output logic [FLAG_W-1:0]        flags_o
);

  localparam int unsigned FP_W  = 1 + EXP_W + MAN_W;
  localparam int unsigned EW2   = EXP_W + 2;
  localparam int unsigned BIAS  = fp_bias(EXP_W);
  localparam int unsigned EMAX  = (32'd1 << EXP_W) - 32'd1;
  localparam int unsigned LOW_W = ITERS - MAN_W - 3;

  localparam logic [FP_W-1:0]  QNAN     = FP_W'(fp_qnan(EXP_W, MAN_W));
  localparam logic [FP_W-2:0]  INF_MAG  = (FP_W-1)'(fp_inf(EXP_W, MAN_W));
  localparam logic [FP_W-2:0]  MAXF_MAG = (FP_W-1)'(fp_max_finite(EXP_W, MAN_W));
  localparam logic [FP_W-2:0]  ZERO_MAG = '0;
  // Quotient bits below the round bit that feed the sticky bit.
  localparam logic [ITERS-1:0] LOW_MASK = ITERS'((CONST_W'(1) << LOW_W) - CONST_W'(1));

  state_e state_q, state_d;

  logic [FP_W-1:0]   a_q, b_q;
  logic [1:0]        rm_q;
  logic [FP_W-1:0]   result_q, result_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;

  logic              accept_c;
  logic              start_c;

  // Operand fields
  logic              sa_c, sb_c, sign_c;
  logic [EXP_W-1:0]  ea_c, eb_c;
  logic [MAN_W-1:0]  fa_c, fb_c;
  logic              a_zero_c, b_zero_c, a_inf_c, b_inf_c, a_nan_c, b_nan_c;

  // Special-case outcome
  logic              spec_c;
  logic [FP_W-1:0]   spec_res_c;
  logic [FLAG_W-1:0] spec_flags_c;

  // Divider interface
  logic              div_busy, div_final, div_done;
  logic [ITERS-1:0]  div_quo;
  logic [MAN_W+1:0]  div_rem;

  // Normalise / round / pack
  logic              int_bit_c;
  logic [ITERS-1:0]  qn_c;
  logic [MAN_W-1:0]  fq_c;
  logic              guard_c, rnd_c, sticky_c, any_c, inc_c;
  logic              fcarry_c;
  logic [MAN_W-1:0]  frac_r_c;
  logic [EW2-1:0]    e_c;
  logic              ovf_c, unf_c;
  logic [FP_W-1:0]   norm_res_c;
  logic [FLAG_W-1:0] norm_flags_c;

  assign accept_c = in_valid_i & in_ready_q;

  // Unpack and classify the captured operands; subnormals read as zero.
  always_comb begin
    sa_c     = a_q[FP_W-1];
    sb_c     = b_q[FP_W-1];
    ea_c     = a_q[FP_W-2 -: EXP_W];
    eb_c     = b_q[FP_W-2 -: EXP_W];
    fa_c     = a_q[MAN_W-1:0];
    fb_c     = b_q[MAN_W-1:0];
    sign_c   = sa_c ^ sb_c;
    a_zero_c = (ea_c == '0);
    b_zero_c = (eb_c == '0);
    a_inf_c  = (&ea_c) & (fa_c == '0);
    b_inf_c  = (&eb_c) & (fb_c == '0);
    a_nan_c  = (&ea_c) & (|fa_c);
    b_nan_c  = (&eb_c) & (|fb_c);
  end

  // Special operands resolve without running the divider.
  always_comb begin
    spec_c       = a_nan_c | b_nan_c | a_zero_c | b_zero_c | a_inf_c | b_inf_c;
    spec_res_c   = {sign_c, ZERO_MAG};
    spec_flags_c = '0;
    if (a_nan_c | b_nan_c) begin
      spec_res_c = QNAN;
    end else if ((a_zero_c & b_zero_c) | (a_inf_c & b_inf_c)) begin
      spec_res_c            = QNAN;
      spec_flags_c[FLAG_NV] = 1'b1;
    end else if (a_inf_c) begin
      // Inf divided by anything finite (including zero) is a clean infinity.
      spec_res_c = {sign_c, INF_MAG};
    end else if (b_zero_c) begin
      spec_res_c            = {sign_c, INF_MAG};
      spec_flags_c[FLAG_DZ] = 1'b1;
    end else begin
      spec_res_c = {sign_c, ZERO_MAG};
    end
  end

  fp_div_iter #(
    .MAN_W (MAN_W),
    .ITERS (ITERS)
  ) u_iter (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (start_c),
    .dividend_i ({1'b1, fa_c}),
    .divisor_i  ({1'b1, fb_c}),
    .busy_o     (div_busy),
    .final_o    (div_final),
    .done_o     (div_done),
    .quo_o      (div_quo),
    .rem_o      (div_rem)
  );

  // Normalise the quotient into [1,2), round, and handle range limits.
  always_comb begin
    int_bit_c = div_quo[ITERS-1];
    qn_c      = int_bit_c ? div_quo : {div_quo[ITERS-2:0], 1'b0};
    fq_c      = qn_c[ITERS-2 -: MAN_W];
    guard_c   = qn_c[ITERS-MAN_W-2];
    rnd_c     = qn_c[ITERS-MAN_W-3];
    sticky_c  = (|(qn_c & LOW_MASK)) | (|div_rem);
    any_c     = guard_c | rnd_c | sticky_c;

    case (rm_q)
      RM_RNE:  inc_c = guard_c & (rnd_c | sticky_c | fq_c[0]);
      RM_RTZ:  inc_c = 1'b0;
      RM_RUP:  inc_c = any_c & ~sign_c;
      RM_RDN:  inc_c = any_c & sign_c;
      default: inc_c = 1'b0;
    endcase

    // Hidden bit is always 1, so a fraction carry means the mantissa hit 2.0.
    {fcarry_c, frac_r_c} = {1'b0, fq_c} + (MAN_W+1)'(inc_c);

    e_c = EW2'(ea_c) - EW2'(eb_c) + EW2'(BIAS) - EW2'(!int_bit_c) + EW2'(fcarry_c);

    ovf_c = ~e_c[EW2-1] & (e_c >= EW2'(EMAX));
    unf_c = e_c[EW2-1] | (e_c == '0);

    norm_flags_c = '0;
    if (ovf_c) begin
      norm_flags_c[FLAG_OF] = 1'b1;
      norm_flags_c[FLAG_NX] = 1'b1;
      case (rm_q)
        RM_RNE:  norm_res_c = {sign_c, INF_MAG};
        RM_RTZ:  norm_res_c = {sign_c, MAXF_MAG};
        RM_RUP:  norm_res_c = sign_c ? {1'b1, MAXF_MAG} : {1'b0, INF_MAG};
        RM_RDN:  norm_res_c = sign_c ? {1'b1, INF_MAG}  : {1'b0, MAXF_MAG};
        default: norm_res_c = {sign_c, INF_MAG};
      endcase
    end else if (unf_c) begin
      norm_res_c            = {sign_c, ZERO_MAG};
      norm_flags_c[FLAG_UF] = 1'b1;
      norm_flags_c[FLAG_NX] = 1'b1;
    end else begin
      norm_res_c            = {sign_c, e_c[EXP_W-1:0], frac_r_c};
      norm_flags_c[FLAG_NX] = any_c;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept_c) state_d = PREP;
      PREP:    state_d = spec_c ? DONE : ITER;
      ITER:    if (div_busy & div_final) state_d = ROUND;
      ROUND:   if (div_done) state_d = DONE;
      DONE:    if (out_valid_q & out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: divider start and next values of the registered outputs
  always_comb begin
    start_c     = 1'b0;
    result_d    = result_q;
    flags_d     = flags_q;
    in_ready_d  = (state_d == IDLE);
    // Valid follows one cycle behind entry into DONE and drops on handshake.
    out_valid_d = (state_q == DONE) & (state_d == DONE);
    case (state_q)
      PREP: begin
        start_c = ~spec_c;
        if (spec_c) begin
          result_d = spec_res_c;
          flags_d  = spec_flags_c;
        end
      end
      ROUND: begin
        result_d = norm_res_c;
        flags_d  = norm_flags_c;
      end
      DONE: begin
        if (state_d == IDLE) flags_d = '0;
      end
      default: ;
    endcase
  end

  // Operand capture and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q         <= '0;
      b_q         <= '0;
      rm_q        <= RM_RNE;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      if (accept_c) begin
        a_q  <= a_i;
        b_q  <= b_i;
        rm_q <= rm_i;
      end
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign result_o    = result_q;
  assign flags_o     = flags_q;

endmodule
